// File: rtl/load_unit.sv
// rtl/load_unit.sv - MEM-stage load unit: in-order tag FIFO, alignment/extension, flush kill counting
module load_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_sign_i,
  input  logic [4:0]        req_rd_i,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [XLEN-1:0]   mem_rsp_data_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_err_o
);

  localparam int OFF_W  = $clog2(XLEN / 8);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int KILL_W = 8;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [1:0]       size;
    logic             sign;
    logic [4:0]       rd;
    logic             err;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  nonerr_q, nonerr_d;   // entries that still owe a memory response
  logic [KILL_W-1:0] kill_q, kill_d;       // responses of flushed loads still to be dropped
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;

  logic              req_err, full, empty, push, pop_err, pop_data, kill_hit, fill;
  entry_t            head;
  logic [XLEN-1:0]   shifted, extended;

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  // Request decode: misalignment / illegal size and the handshake towards memory
  always_comb begin
    req_err = (req_size_i == 2'b01 && req_addr_i[0])
           || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
           || (req_size_i == 2'b11 && (XLEN == 32 || req_addr_i[2:0] != 3'b000));
  end

  assign full            = (count_q == CNT_W'(DEPTH));
  assign empty           = (count_q == '0);
  assign mem_req_valid_o = req_valid_i & ~full & ~req_err & ~flush_i;
  assign req_ready_o     = ~full & ~flush_i & (req_err | mem_req_ready_i);
  assign push            = req_valid_i & req_ready_o;
  assign mem_addr_o      = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign head            = fifo_q[rd_idx_q];

  // Align returned data to the head entry's byte offset and extend it to XLEN
  always_comb begin
    int w;
    shifted = mem_rsp_data_i >> {head.off, 3'b000};
    w = 8 << head.size;
    if (w > XLEN) w = XLEN;
    case (head.size)
      2'b00:   fill = head.sign & shifted[7];
      2'b01:   fill = head.sign & shifted[15];
      2'b10:   fill = head.sign & shifted[31];
      default: fill = head.sign & shifted[XLEN-1];
    endcase
    for (int i = 0; i < XLEN; i++) begin
      extended[i] = (i < w) ? shifted[i] : fill;
    end
  end

  // FIFO bookkeeping, kill counting and result register next-state
  always_comb begin
    fifo_d      = fifo_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    count_d     = count_q;
    nonerr_d    = nonerr_q;
    kill_d      = kill_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;

    pop_err  = ~empty & head.err;
    pop_data = ~empty & ~head.err & mem_rsp_valid_i & (kill_q == '0);
    kill_hit = mem_rsp_valid_i & (kill_q != '0);

    if (flush_i) begin
      // A response arriving now settles either an older kill or the (now flushed) head.
      rd_idx_d = '0;
      wr_idx_d = '0;
      count_d  = '0;
      nonerr_d = '0;
      kill_d   = kill_q + KILL_W'(nonerr_q) - KILL_W'(kill_hit | pop_data);
    end else begin
      if (kill_hit) kill_d = kill_q - KILL_W'(1);
      if (pop_err || pop_data) begin
        rd_idx_d    = idx_next(rd_idx_q);
        count_d     = count_d - CNT_W'(1);
        rsp_valid_d = 1'b1;
        rsp_rd_d    = head.rd;
        rsp_err_d   = pop_err;
        rsp_data_d  = pop_err ? '0 : extended;
        if (pop_data) nonerr_d = nonerr_d - CNT_W'(1);
      end
      if (push) begin
        fifo_d[wr_idx_q] = '{off: req_addr_i[OFF_W-1:0], size: req_size_i,
                             sign: req_sign_i, rd: req_rd_i, err: req_err};
        wr_idx_d = idx_next(wr_idx_q);
        count_d  = count_d + CNT_W'(1);
        if (!req_err) nonerr_d = nonerr_d + CNT_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      count_q     <= '0;
      nonerr_q    <= '0;
      kill_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      count_q     <= count_d;
      nonerr_q    <= nonerr_d;
      kill_q      <= kill_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;

  // A memory response with nothing waiting for it means the memory side broke ordering
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid_i && empty && kill_q == '0));

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - scoreboard bench for load_unit (XLEN=32, DEPTH=2)
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_sign_i, flush_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i;
  logic [31:0] mem_addr_o, mem_rsp_data_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   rsp_cnt = 0;
  int   c0;

  load_unit #(.XLEN(32), .ADDR_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_sign_i(req_sign_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
    .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid_o) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", rsp_data_o, e.data);
        check("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
        check("rsp_err", 32'(rsp_err_o), 32'(e.err));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [4:0] rd, input logic [31:0] data,
                         input logic err);
    int n;
    exp_t e;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_size_i  = size;
    req_sign_i  = sign;
    req_rd_i    = rd;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 20) break;
    end
    if (n > 20) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_mem_req_valid"}, 32'(mem_req_valid_o), 32'(!err));
      if (!err) check({tag, "_mem_addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
      e.rd = rd;
      e.data = err ? 32'd0 : data;
      e.err = err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic mem_rsp(input logic [31:0] data);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = data;
    @(posedge clk);
    #1;
    mem_rsp_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t2_addr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
  logic [1:0]  t2_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  logic        t2_sign [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t2_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012,
                               32'h0000_3456, 32'h0000_0034};

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_size_i = '0; req_sign_i = 1'b0; req_rd_i = '0;
    flush_i = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rsp_data", rsp_data_o, 32'd0);
    check("reset_rsp_rd", 32'(rsp_rd_o), 32'd0);
    check("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;

    // Aligned word load with one-cycle result latency
    do_load("t1", 32'h100, 2'b10, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    mem_rsp(32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_latency", 32'(rsp_valid_o), 32'd1);
    @(posedge clk);
    #1;
    wait_drain("t1");

    // Sub-word loads: offsets, sign and zero extension
    for (int i = 0; i < 5; i++) begin
      do_load("t2", t2_addr[i], t2_size[i], t2_sign[i], 5'(i + 1), t2_exp[i], 1'b0);
      mem_rsp(32'h8012_3456);
      wait_drain("t2");
    end

    // Misaligned load stays behind an older pending load
    do_load("t3_lw", 32'h200, 2'b10, 1'b1, 5'd7, 32'h1122_3344, 1'b0);
    do_load("t3_lh", 32'h101, 2'b01, 1'b1, 5'd9, 32'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t3_held", 32'(rsp_valid_o), 32'd0);
    end
    @(posedge clk);
    #1;
    mem_rsp(32'h1122_3344);
    wait_drain("t3");
    @(negedge clk);
    check("t3_err_cleared", 32'(rsp_err_o), 32'd0);
    check("t3_rd_hold", 32'(rsp_rd_o), 32'd9);
    @(posedge clk);
    #1;
    do_load("t3_lw_mis", 32'h102, 2'b10, 1'b0, 5'd3, 32'd0, 1'b1);
    wait_drain("t3b");

    // Memory backpressure holds the request
    mem_req_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 32'h700; req_size_i = 2'b10; req_rd_i = 5'd20;
    @(negedge clk);
    check("bp_ready", 32'(req_ready_o), 32'd0);
    check("bp_mem_valid", 32'(mem_req_valid_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;

    // Full FIFO: no enqueue, even while a dequeue happens
    do_load("t4_a", 32'h300, 2'b10, 1'b0, 5'd1, 32'hA1A1_A1A1, 1'b0);
    do_load("t4_b", 32'h304, 2'b10, 1'b0, 5'd2, 32'hB2B2_B2B2, 1'b0);
    req_valid_i = 1'b1; req_addr_i = 32'h308; req_size_i = 2'b10; req_rd_i = 5'd3;
    @(negedge clk);
    check("t4_full_ready", 32'(req_ready_o), 32'd0);
    check("t4_full_mem_valid", 32'(mem_req_valid_o), 32'd0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 32'hA1A1_A1A1;
    @(negedge clk);
    check("t4_full_deq_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("t4_ready_back", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    mem_rsp(32'hB2B2_B2B2);
    wait_drain("t4");

    // Flush with two loads in flight: their responses are dropped
    do_load("t5_a", 32'h400, 2'b10, 1'b0, 5'd10, 32'h1111_1111, 1'b0);
    do_load("t5_b", 32'h404, 2'b10, 1'b0, 5'd11, 32'h2222_2222, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    check("t5_flush_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    sb.delete();
    c0 = rsp_cnt;
    do_load("t5_c", 32'h408, 2'b10, 1'b0, 5'd12, 32'hCAFE_F00D, 1'b0);
    mem_rsp(32'h1111_1111);
    mem_rsp(32'h2222_2222);
    @(negedge clk);
    check("t5_dropped", 32'(rsp_cnt - c0), 32'd0);
    @(posedge clk);
    #1;
    mem_rsp(32'hCAFE_F00D);
    wait_drain("t5");
    check("t5_pulses", 32'(rsp_cnt - c0), 32'd1);

    // Asynchronous reset with a load outstanding
    do_load("t6_a", 32'h500, 2'b10, 1'b0, 5'd4, 32'h5555_5555, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rsp_valid_o), 32'd0);
    check("t6_rst_data", rsp_data_o, 32'd0);
    check("t6_rst_rd", 32'(rsp_rd_o), 32'd0);
    check("t6_rst_err", 32'(rsp_err_o), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_load("t6_b", 32'h600, 2'b10, 1'b1, 5'd6, 32'h0BAD_F00D, 1'b0);
    mem_rsp(32'h0BAD_F00D);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
